// File: rtl/sim_uart_host_rx.sv
// Host-side UART receiver (8N1/8E1/8O1) feeding a first-word-fall-through byte FIFO.
// A byte is pushed on the stop-bit mid-sample edge; a full FIFO drops it and pulses overrun unless popped that cycle.
module sim_uart_host_rx #(
    parameter int SYS_CLK_FREQ   = 100000000,
    parameter int BAUD_RATE      = 115200,
    parameter int PARITY_MODE    = 0,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH   = 1 << FIFO_ADDR_BITS;
    localparam int CNTW    = FIFO_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_sync1, r_sync2;
    logic [TCW-1:0]            r_tcnt;
    logic [3:0]                r_s;
    logic [2:0]                r_bit;
    logic [7:0]                r_shift;
    logic                      r_par;
    logic                      r_parity_err, r_frame_err, r_overrun;
    logic [7:0]                r_mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] r_wptr, r_rptr;
    logic [CNTW-1:0]           r_count;

    logic w_rxs, w_tick, w_par_xor, w_par_ok;
    logic w_start, w_mid_start, w_sample, w_par_sample, w_resolve;
    logic w_empty, w_full, w_push_req, w_wr, w_rd, w_ovr;

    assign w_rxs     = r_sync2;
    assign w_tick    = (r_tcnt == TCW'(DIV - 1));
    assign w_par_xor = ^{r_shift, r_par};
    assign w_par_ok  = (PARITY_MODE == 1) ? w_par_xor :
                       (PARITY_MODE == 2) ? ~w_par_xor : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_rxs) w_next = S_START;
            S_START:     if (w_tick && r_s == 4'd7) w_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA:      if (w_tick && r_s == 4'd15 && r_bit == 3'd7)
                             w_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_tick && r_s == 4'd15) w_next = S_STOP;
            S_STOP:      if (w_tick && r_s == 4'd15) w_next = w_rxs ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (w_rxs) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start      = 1'b0;
        w_mid_start  = 1'b0;
        w_sample     = 1'b0;
        w_par_sample = 1'b0;
        w_resolve    = 1'b0;
        case (r_state)
            S_IDLE:   w_start      = ~w_rxs;
            S_START:  w_mid_start  = w_tick && (r_s == 4'd7);
            S_DATA:   w_sample     = w_tick && (r_s == 4'd15);
            S_PARITY: w_par_sample = w_tick && (r_s == 4'd15);
            S_STOP:   w_resolve    = w_tick && (r_s == 4'd15);
            default:  ;
        endcase
    end

    // Sample counter wraps 15->0 on its own, so each bit period restarts at s=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt  <= '0;
            r_s     <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if (w_start || w_tick) r_tcnt <= '0;
            else                   r_tcnt <= r_tcnt + TCW'(1);
            if (w_start || w_mid_start) r_s <= '0;
            else if (w_tick)            r_s <= r_s + 4'd1;
            if (w_mid_start)   r_bit <= '0;
            else if (w_sample) r_bit <= r_bit + 3'd1;
            if (w_sample)     r_shift <= {w_rxs, r_shift[7:1]};
            if (w_par_sample) r_par   <= w_rxs;
        end
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_push_req = w_resolve & w_rxs & w_par_ok;
    assign w_rd       = rd_en & ~w_empty;
    assign w_wr       = w_push_req & (~w_full | w_rd);
    assign w_ovr      = w_push_req & w_full & ~w_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + FIFO_ADDR_BITS'(1);
            if (w_rd) r_rptr <= r_rptr + FIFO_ADDR_BITS'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            r_parity_err <= w_resolve & ~w_par_ok;
            r_frame_err  <= w_resolve & ~w_rxs;
            r_overrun    <= w_ovr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    assign rd_data    = w_empty ? 8'h00 : r_mem[r_rptr];
    assign empty      = w_empty;
    assign full       = w_full;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sim_uart_host_rx.sv
// Directed bench: one no-parity receiver and one even-parity receiver share the rx line and reset.
module tb_sim_uart_host_rx;

    localparam int SYS  = 1600000;
    localparam int BAUD = 10000;
    localparam int BIT  = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx, rd_en0, rd_en2;
    logic [7:0] rd_data0, rd_data2;
    logic       empty0, full0, perr0, ferr0, ovr0;
    logic       empty2, full2, perr2, ferr2, ovr2;

    int checks = 0;
    int errors = 0;
    int n_perr0 = 0, n_ferr0 = 0, n_ovr0 = 0;
    int n_perr2 = 0, n_ferr2 = 0, n_ovr2 = 0;

    sim_uart_host_rx #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .PARITY_MODE(0), .FIFO_ADDR_BITS(3)) dut0 (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0),
        .full(full0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0));

    sim_uart_host_rx #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .PARITY_MODE(2), .FIFO_ADDR_BITS(3)) dut2 (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en2), .rd_data(rd_data2), .empty(empty2),
        .full(full2), .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2));

    always @(posedge clk) begin
        if (perr0) n_perr0 <= n_perr0 + 1;
        if (ferr0) n_ferr0 <= n_ferr0 + 1;
        if (ovr0)  n_ovr0  <= n_ovr0 + 1;
        if (perr2) n_perr2 <= n_perr2 + 1;
        if (ferr2) n_ferr2 <= n_ferr2 + 1;
        if (ovr2)  n_ovr2  <= n_ovr2 + 1;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level; callers return the line to idle.
    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic par, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (BIT) @(negedge clk);
        end
        if (use_par) begin
            rx = par;
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pop0();
        rd_en0 = 1'b1;
        @(negedge clk);
        rd_en0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rd_en0 = 1'b0; rd_en2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full0); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data0); end
        checks++; if ({perr0, ferr0, ovr0} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {perr0, ferr0, ovr0}); end
        checks++; if ({empty2, full2, perr2, ferr2, ovr2} !== 5'b10000) begin errors++; $display("FAIL reset_par_dut got %b exp 10000", {empty2, full2, perr2, ferr2, ovr2}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat = -1;
        int p = n_perr0, f = n_ferr0, o = n_ovr0;
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b1);
            begin
                for (int k = 1; k <= 2000; k++) begin
                    @(negedge clk);
                    if (!empty0) begin lat = k; break; end
                end
            end
        join
        idle(20);
        checks++; if (lat < 1520 || lat > 1526) begin errors++; $display("FAIL basic_latency got %0d exp 1520..1526", lat); end
        checks++; if (rd_data0 !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", rd_data0); end
        checks++; if ((n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o) != 0) begin errors++; $display("FAIL basic_pulses got %0d exp 0", (n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o)); end
        pop0();
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL basic_pop_empty got %b exp 1", empty0); end
    endtask

    task automatic test_parity();
        int p, f, o;
        do_reset();
        p = n_perr2; f = n_ferr2; o = n_ovr2;
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
        idle(40);
        checks++; if (empty2 !== 1'b0) begin errors++; $display("FAIL par_good_empty got %b exp 0", empty2); end
        checks++; if (rd_data2 !== 8'hA3) begin errors++; $display("FAIL par_good_data got %h exp a3", rd_data2); end
        checks++; if ((n_perr2 - p) + (n_ferr2 - f) + (n_ovr2 - o) != 0) begin errors++; $display("FAIL par_good_pulses got %0d exp 0", (n_perr2 - p) + (n_ferr2 - f) + (n_ovr2 - o)); end
        rd_en2 = 1'b1;
        @(negedge clk);
        rd_en2 = 1'b0;
        p = n_perr2; f = n_ferr2;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        idle(40);
        checks++; if (n_perr2 - p != 1) begin errors++; $display("FAIL par_bad_perr got %0d exp 1", n_perr2 - p); end
        checks++; if (n_ferr2 - f != 0) begin errors++; $display("FAIL par_bad_ferr got %0d exp 0", n_ferr2 - f); end
        checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL par_bad_empty got %b exp 1", empty2); end
    endtask

    task automatic test_frame_err();
        int p, f, o;
        do_reset();
        p = n_perr0; f = n_ferr0; o = n_ovr0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        idle(2 * BIT);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        idle(40);
        checks++; if (n_ferr0 - f != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_ferr0 - f); end
        checks++; if ((n_perr0 - p) + (n_ovr0 - o) != 0) begin errors++; $display("FAIL ferr_other_pulses got %0d exp 0", (n_perr0 - p) + (n_ovr0 - o)); end
        checks++; if (rd_data0 !== 8'h12) begin errors++; $display("FAIL ferr_next_data got %h exp 12", rd_data0); end
        pop0();
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL ferr_only_one got %b exp 1", empty0); end
    endtask

    task automatic test_glitch();
        int p = n_perr0, f = n_ferr0, o = n_ovr0;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(2 * BIT);
        checks++; if ((n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o) != 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", (n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o)); end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL glitch_empty got %b exp 1", empty0); end
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        idle(40);
        checks++; if (empty0 !== 1'b0 || rd_data0 !== 8'h7E) begin errors++; $display("FAIL glitch_next got empty=%b data=%h exp empty=0 data=7e", empty0, rd_data0); end
        pop0();
    endtask

    task automatic test_fifo();
        int o;
        logic [7:0] exp_d;
        do_reset();
        o = n_ovr0;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1);
            idle(20);
            if (i == 6) begin
                checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL fifo_seven_full got %b exp 0", full0); end
            end
        end
        checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fifo_eight_full got %b exp 1", full0); end
        checks++; if (n_ovr0 - o != 0) begin errors++; $display("FAIL fifo_early_ovr got %0d exp 0", n_ovr0 - o); end
        send_frame(8'h08, 1'b0, 1'b0, 1'b1);
        idle(20);
        checks++; if (n_ovr0 - o != 1) begin errors++; $display("FAIL fifo_overrun got %0d exp 1", n_ovr0 - o); end
        checks++; if (full0 !== 1'b1 || rd_data0 !== 8'h00) begin errors++; $display("FAIL fifo_after_ovr got full=%b head=%h exp full=1 head=00", full0, rd_data0); end
        o = n_ovr0;
        // Push lands on the edge after the 1522nd negedge from the start bit.
        fork
            send_frame(8'h09, 1'b0, 1'b0, 1'b1);
            begin
                repeat (1522) @(negedge clk);
                rd_en0 = 1'b1;
                @(negedge clk);
                rd_en0 = 1'b0;
            end
        join
        idle(20);
        checks++; if (n_ovr0 - o != 0) begin errors++; $display("FAIL fifo_pushpop_ovr got %0d exp 0", n_ovr0 - o); end
        checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fifo_pushpop_full got %b exp 1", full0); end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 7) ? 8'(i + 1) : 8'h09;
            checks++; if (rd_data0 !== exp_d) begin errors++; $display("FAIL fifo_read%0d got %h exp %h", i, rd_data0, exp_d); end
            pop0();
        end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL fifo_drained got %b exp 1", empty0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int p = n_perr0, f = n_ferr0, o = n_ovr0;
        d = 8'hA5;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rx = d[b];
            repeat (BIT) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty0); end
        rx = 1'b1;
        rst = 1'b0;
        idle(2 * BIT);
        checks++; if ((n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o) != 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", (n_perr0 - p) + (n_ferr0 - f) + (n_ovr0 - o)); end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rstmid_no_frame got %b exp 1", empty0); end
        send_frame(8'hC9, 1'b0, 1'b0, 1'b1);
        idle(40);
        checks++; if (empty0 !== 1'b0 || rd_data0 !== 8'hC9) begin errors++; $display("FAIL rstmid_next got empty=%b data=%h exp empty=0 data=c9", empty0, rd_data0); end
        pop0();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_fifo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
